// File: rtl/alu_exec_unit.sv
// RV32I/M integer execute unit: decodes the ALU class, registers the result
// behind a valid/ready handshake, and runs mul/div on a radix-2 iterative engine.
module alu_exec_unit #(
    parameter int XLEN      = 32,
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op5,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            br_taken,
    output logic            illegal,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] LAST = SW'(XLEN - 1);

    typedef enum logic {IDLE, ITER} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   srca_q, srca_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic              div0_q, div0_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              br_q, br_d;
    logic              ill_q, ill_d;
    logic              ov_q, ov_d;

    logic [XLEN-1:0]   sc_res, diff;
    logic              sc_br, sc_ill, is_mop;
    logic [SW-1:0]     shamt;
    logic              accept, start_m;
    logic              sgn_a, sgn_b;
    logic [XLEN-1:0]   mag_a, mag_b;

    assign in_ready  = (state_q == IDLE) && (!ov_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_m   = accept && is_mop && EN_MULDIV;
    assign out_valid = ov_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign br_taken  = br_q;
    assign illegal   = ill_q;
    assign busy      = (state_q == ITER);
    assign shamt     = src_b[SW-1:0];
    assign diff      = src_a - src_b;

    always_comb begin
        sc_res = '0;
        sc_br  = 1'b0;
        sc_ill = 1'b0;
        is_mop = 1'b0;
        unique case (alu_op)
            2'b00: sc_res = src_a + src_b;
            2'b01: begin
                sc_res = diff;
                unique case (funct3)
                    3'b000:  sc_br = (src_a == src_b);
                    3'b001:  sc_br = (src_a != src_b);
                    3'b100:  sc_br = ($signed(src_a) < $signed(src_b));
                    3'b101:  sc_br = ($signed(src_a) >= $signed(src_b));
                    3'b110:  sc_br = (src_a < src_b);
                    3'b111:  sc_br = (src_a >= src_b);
                    default: sc_ill = 1'b1;
                endcase
            end
            2'b10: begin
                if (op5 && funct7 == 7'b0000001) begin
                    is_mop = 1'b1;
                    sc_ill = !EN_MULDIV;
                end else begin
                    unique case (funct3)
                        3'b000: sc_res = (op5 && funct7[5]) ? diff
                                                            : src_a + src_b;
                        3'b001: sc_res = src_a << shamt;
                        3'b010: sc_res = {{(XLEN-1){1'b0}},
                                          $signed(src_a) < $signed(src_b)};
                        3'b011: sc_res = {{(XLEN-1){1'b0}}, src_a < src_b};
                        3'b100: sc_res = src_a ^ src_b;
                        3'b101: sc_res = funct7[5]
                                         ? $unsigned($signed(src_a) >>> shamt)
                                         : src_a >> shamt;
                        3'b110: sc_res = src_a | src_b;
                        default: sc_res = src_a & src_b;
                    endcase
                end
            end
            default: sc_res = src_b;
        endcase
    end

    // Engine works on magnitudes; sign is restored on the final step.
    assign sgn_a = src_a[XLEN-1] &&
                   (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    assign sgn_b = src_b[XLEN-1] && (funct3 inside {3'b001, 3'b100, 3'b110});
    assign mag_a = sgn_a ? -src_a : src_a;
    assign mag_b = sgn_b ? -src_b : src_b;

    logic [XLEN:0]     mul_sum, div_rs, div_df;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
    logic [XLEN-1:0]   dv, m_res;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
        div_rs  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_df  = div_rs - {1'b0, opnd_q};
        div_nxt = div_df[XLEN]
                ? {div_rs[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                : {div_df[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod    = neg_q ? -mul_nxt : mul_nxt;
        dv      = f3_q[1] ? div_nxt[2*XLEN-1:XLEN] : div_nxt[XLEN-1:0];
        if (!f3_q[2])
            m_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                         : prod[2*XLEN-1:XLEN];
        else if (div0_q)
            m_res = f3_q[1] ? srca_q : '1;
        else
            m_res = neg_q ? -dv : dv;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        srca_d   = srca_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        result_d = result_q;
        zero_d   = zero_q;
        br_d     = br_q;
        ill_d    = ill_q;
        ov_d     = ov_q && !out_ready;
        unique case (state_q)
            IDLE: begin
                if (start_m) begin
                    state_d = ITER;
                    cnt_d   = '0;
                    f3_d    = funct3;
                    acc_d   = {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
                    opnd_d  = funct3[2] ? mag_b : mag_a;
                    neg_d   = (funct3[2] && funct3[1]) ? sgn_a : sgn_a ^ sgn_b;
                    div0_d  = (src_b == '0);
                    srca_d  = src_a;
                    ov_d    = 1'b0;
                    br_d    = 1'b0;
                    ill_d   = 1'b0;
                end else if (accept) begin
                    result_d = sc_res;
                    zero_d   = (sc_res == '0);
                    br_d     = sc_br;
                    ill_d    = sc_ill;
                    ov_d     = 1'b1;
                end
            end
            default: begin
                acc_d = f3_q[2] ? div_nxt : mul_nxt;
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == LAST) begin
                    state_d  = IDLE;
                    result_d = m_res;
                    zero_d   = (m_res == '0);
                    ov_d     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            srca_q   <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            srca_q   <= srca_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            br_q     <= br_d;
            ill_q    <= ill_d;
            ov_q     <= ov_d;
        end
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decoder.
- Decodes alu_op/funct3/funct7/op5 for the full RV32I integer op set plus branch compare and the optional M extension, and executes the operation.
- Registered result behind a valid/ready handshake; iterative multiply/divide engine.
- Sits between the control unit/register-file read stage and writeback.

Parameters:
XLEN, 32, datapath width; power of 2, minimum 8
EN_MULDIV, 1, 1 = M-extension ops implemented; 0 = flagged illegal

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request this cycle
op5  input  1  opcode bit 5 (1 = R-type, 0 = I-type)
alu_op  input  2  class from control unit
funct3  input  3  instruction funct3
funct7  input  7  instruction funct7
src_a  input  XLEN  operand A
src_b  input  XLEN  operand B / immediate
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  registered result
zero  output  1  result == 0
br_taken  output  1  branch condition true (alu_op=01 only, else 0)
illegal  output  1  undecodable op
busy  output  1  iterative op in progress

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: FSM to IDLE. All outputs 0 (result, zero, br_taken, illegal, out_valid, busy); in_ready=1.
- Asserting rst_n low mid-iteration aborts the operation; no result is produced.
- Acceptance: a request is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Back-to-back single-cycle ops therefore sustain 1 op/cycle.
- Output hold: once out_valid=1, result, zero, br_taken and illegal hold stable until out_valid && out_ready.
  - If a new accept and an output handshake occur in the same cycle, the new result loads.
- Decode by alu_op:
  - 00: add.
  - 01: branch. result = a-b; br_taken by funct3:
    - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
    - 010 and 011: br_taken=0, illegal=1.
  - 10: ALU.
    - If op5=1 and funct7=0000001: M-op.
    - Otherwise, by funct3:
      - 000: add; sub when op5=1 && funct7[5]=1.
      - 001: sll.
      - 010: slt.
      - 011: sltu.
      - 100: xor.
      - 101: srl; sra when funct7[5]=1.
      - 110: or.
      - 111: and.
    - Shift amount is src_b[log2(XLEN)-1:0].
  - 11: pass src_b (lui).
- Single-cycle ops: accepted in cycle N, out_valid=1 in cycle N+1.
- M-ops (funct3):
  - 000 mul (low word), 001 mulh, 010 mulhsu, 011 mulhu.
  - 100 div, 101 divu, 110 rem, 111 remu.
  - FSM IDLE -> ITER (XLEN cycles, one radix-2 step per cycle, busy=1) -> IDLE with out_valid=1.
  - Accept in cycle N gives out_valid in cycle N+XLEN+1, fixed for all operand values.
  - Signed variants use magnitude on entry and sign-fix on exit.
- Division special cases (fixed latency retained):
  - Divisor 0: quotient = all ones; remainder = src_a.
  - Signed overflow (src_a = -2^(XLEN-1), src_b = -1): quotient = src_a; remainder = 0.
- EN_MULDIV=0: M-ops complete in 1 cycle with result=0, illegal=1.
- Width rules: all arithmetic is modulo 2^XLEN. slt/sltu results are zero-extended 0/1. zero is computed from the registered result.

Test Plan:
- XLEN=32, alu_op=10, op5=1, funct7=0100000, funct3=000, a=5, b=7 -> next cycle result=0xFFFFFFFE, zero=0; same operands with op5=0 -> result=12 (addi never subtracts).
- alu_op=01, funct3=100, a=0xFFFFFFFF, b=1 -> br_taken=1; funct3=110 with same operands -> br_taken=0; a=b=3, funct3=000 -> zero=1, br_taken=1.
- M div, a=-7 (0xFFFFFFF9), b=2, accepted cycle 0 -> busy for 32 cycles, out_valid at cycle 33, result=0xFFFFFFFD; rem -> 0xFFFFFFFF.
- divu by 0, a=0x1234 -> quotient=0xFFFFFFFF; remu by 0 -> 0x1234; div 0x80000000 by 0xFFFFFFFF -> 0x80000000; rem -> 0; all at latency 33.
- mulhu, a=b=0xFFFFFFFF -> 0xFFFFFFFE; mul -> 0x00000001. With out_ready held low 5 cycles: result stable, in_ready=0 until the handshake completes.
- rst_n low at cycle 10 of a div -> outputs 0 immediately (asynchronous); after release, an add of 1+1 completes in 1 cycle with result=2.
